// File: rtl/dtree_pkg.sv
// Shared types and constants for the decision-tree vote collector.
// Imported by the collector top and its argmax scan engine.
package dtree_pkg;

  localparam int CLASS_W = 4;
  localparam logic [CLASS_W-1:0] NO_CLASS = 4'hF;
  localparam int DEF_NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    HOLD    = 2'd2
  } state_e;

  typedef struct packed {
    logic [CLASS_W-1:0] cls;
    logic [7:0]         votes;
  } result_t;

endpackage

// File: rtl/dtree_argmax_scan.sv
// Sequential argmax: walks one class count per cycle after start.
// Ties keep the lower index since only a strictly greater count wins.
module dtree_argmax_scan
  import dtree_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         cnt_i,
  output logic [CLASS_W-1:0] idx_o,
  output logic [CLASS_W-1:0] best_idx_o,
  output logic [7:0]         best_cnt_o,
  output logic               done_o
);

  localparam logic [CLASS_W-1:0] LAST = CLASS_W'(NUM_CLASSES - 1);

  logic               active_q, active_d;
  logic [CLASS_W-1:0] idx_q, idx_d;
  logic [CLASS_W-1:0] bidx_q, bidx_d;
  logic [7:0]         bcnt_q, bcnt_d;
  logic               take;

  assign idx_o  = idx_q;
  assign take   = active_q && (cnt_i > bcnt_q);
  assign done_o = active_q && (idx_q == LAST);

  // Best outputs already fold in the count under examination.
  assign best_idx_o = take ? idx_q : bidx_q;
  assign best_cnt_o = take ? cnt_i : bcnt_q;

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    bidx_d   = bidx_q;
    bcnt_d   = bcnt_q;
    if (start) begin
      active_d = 1'b1;
      idx_d    = '0;
      bidx_d   = '0;
      bcnt_d   = '0;
    end else if (active_q) begin
      idx_d  = idx_q + 1'b1;
      bidx_d = best_idx_o;
      bcnt_d = best_cnt_o;
      if (done_o) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      bidx_q   <= '0;
      bcnt_q   <= '0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      bidx_q   <= bidx_d;
      bcnt_q   <= bcnt_d;
    end
  end

endmodule

// File: rtl/dtree_vote_collector.sv
// Collects WINDOW tree predictions into a class histogram, then
// reports the majority class via a sequential argmax scan.
module dtree_vote_collector
  import dtree_pkg::*;
#(
  parameter int WINDOW      = 8,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [CLASS_W-1:0] in_class,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic [7:0]         out_votes,
  output logic               out_illegal
);

  state_e     state_q, state_d;
  logic [7:0] hist_q [NUM_CLASSES];
  logic [7:0] hist_d [NUM_CLASSES];
  logic [7:0] win_q, win_d;
  logic       ill_q, ill_d;
  result_t    res_q, res_d;
  logic       ovalid_q, ovalid_d;
  logic       oill_q, oill_d;

  logic               xfer, legal, start, scan_done;
  logic [CLASS_W-1:0] scan_idx, best_idx;
  logic [7:0]         scan_cnt, best_cnt;

  assign in_ready    = (state_q == COLLECT);
  assign xfer        = in_valid && in_ready;
  assign legal       = int'(in_class) < NUM_CLASSES;
  assign start       = xfer && (win_q == 8'(WINDOW - 1));
  assign out_valid   = ovalid_q;
  assign out_class   = res_q.cls;
  assign out_votes   = res_q.votes;
  assign out_illegal = oill_q;

  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (scan_idx == CLASS_W'(i)) scan_cnt = hist_q[i];
  end

  dtree_argmax_scan #(
    .NUM_CLASSES(NUM_CLASSES)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cnt_i     (scan_cnt),
    .idx_o     (scan_idx),
    .best_idx_o(best_idx),
    .best_cnt_o(best_cnt),
    .done_o    (scan_done)
  );

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    win_d    = win_q;
    ill_d    = ill_q;
    res_d    = res_q;
    ovalid_d = ovalid_q;
    oill_d   = oill_q;
    unique case (state_q)
      COLLECT: begin
        if (xfer) begin
          win_d = win_q + 8'd1;
          if (legal) begin
            for (int i = 0; i < NUM_CLASSES; i++)
              if (in_class == CLASS_W'(i))
                hist_d[i] = hist_q[i] + 8'd1;
          end else begin
            ill_d = 1'b1;
          end
          if (start) state_d = SCAN;
        end
      end
      SCAN: begin
        if (scan_done) begin
          state_d     = HOLD;
          ovalid_d    = 1'b1;
          oill_d      = ill_q;
          res_d.cls   = (best_cnt == 8'd0) ? NO_CLASS : best_idx;
          res_d.votes = best_cnt;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d  = COLLECT;
          ovalid_d = 1'b0;
          oill_d   = 1'b0;
          res_d    = '0;
          win_d    = '0;
          ill_d    = 1'b0;
          for (int i = 0; i < NUM_CLASSES; i++)
            hist_d[i] = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      win_q    <= '0;
      ill_q    <= 1'b0;
      res_q    <= '0;
      ovalid_q <= 1'b0;
      oill_q   <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++)
        hist_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      ill_q    <= ill_d;
      res_q    <= res_d;
      ovalid_q <= ovalid_d;
      oill_q   <= oill_d;
      for (int i = 0; i < NUM_CLASSES; i++)
        hist_q[i] <= hist_d[i];
    end
  end

endmodule

// File: tb/tb_dtree_vote_collector.sv
// Directed self-checking bench for dtree_vote_collector.
// Default parameters: WINDOW=8, NUM_CLASSES=10.
module tb_dtree_vote_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_class;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_class;
  logic [7:0] out_votes;
  logic       out_illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dtree_vote_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_class   (in_class),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_votes  (out_votes),
    .out_illegal(out_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] c);
    in_valid = 1'b1;
    in_class = c;
    tick();
    in_valid = 1'b0;
  endtask

  // Eight nibbles, first prediction in the top nibble.
  task automatic send_win(input logic [31:0] v);
    for (int i = 0; i < 8; i++) send(v[31-4*i -: 4]);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  function automatic void model(input logic [31:0] v,
                                output logic [3:0] cls,
                                output logic [7:0] votes,
                                output logic ill);
    int h [16];
    int bi, bc;
    for (int i = 0; i < 16; i++) h[i] = 0;
    ill = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (v[31-4*i -: 4] < 4'd10) h[v[31-4*i -: 4]]++;
      else ill = 1'b1;
    end
    bi = 0;
    bc = 0;
    for (int i = 0; i < 10; i++)
      if (h[i] > bc) begin
        bc = h[i];
        bi = i;
      end
    cls   = (bc == 0) ? 4'hF : 4'(bi);
    votes = 8'(bc);
  endfunction

  initial begin
    int lat;
    logic [3:0] m_cls;
    logic [7:0] m_votes;
    logic       m_ill;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_class  = 4'd0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_out_votes", 32'(out_votes), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Basic majority and latency
    send_win(32'h3337_7130);
    chk("a_in_ready_scan", 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk("a_latency", 32'(lat), 32'd10);
    chk("a_class", 32'(out_class), 32'd3);
    chk("a_votes", 32'(out_votes), 32'd4);
    chk("a_illegal", 32'(out_illegal), 32'd0);
    tick();
    chk("a_consumed", 32'(out_valid), 32'd0);
    chk("a_in_ready", 32'(in_ready), 32'd1);

    // Tie resolves to lowest index
    send_win(32'h5252_5299);
    wait_valid(lat);
    chk("tie_valid", 32'(out_valid), 32'd1);
    chk("tie_class", 32'(out_class), 32'd2);
    chk("tie_votes", 32'(out_votes), 32'd3);
    tick();

    // Only illegal codes
    send_win(32'hCCCC_CCCC);
    wait_valid(lat);
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_class", 32'(out_class), 32'hF);
    chk("ill_votes", 32'(out_votes), 32'd0);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    tick();
    chk("ill_consumed", 32'(out_valid), 32'd0);

    // Backpressure in HOLD with upstream traffic
    out_ready = 1'b0;
    send_win(32'h1144_4002);
    wait_valid(lat);
    chk("hold_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_class = 4'(i % 10);
      tick();
      chk("hold_stable",
          {18'd0, out_valid, in_ready, out_illegal, out_class, out_votes},
          {18'd0, 1'b1, 1'b0, 1'b0, 4'h4, 8'd3});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold_released", 32'(out_valid), 32'd0);
    send_win(32'h0011_1555);
    wait_valid(lat);
    chk("post_hold_class", 32'(out_class), 32'd1);
    chk("post_hold_votes", 32'(out_votes), 32'd3);
    tick();

    // Reset in the middle of the scan
    send_win(32'h11F2_3456);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("scan_rst_valid", 32'(out_valid), 32'd0);
    chk("scan_rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    send_win(32'h6666_6666);
    wait_valid(lat);
    chk("after_rst_class", 32'(out_class), 32'd6);
    chk("after_rst_votes", 32'(out_votes), 32'd8);
    chk("after_rst_illegal", 32'(out_illegal), 32'd0);
    tick();

    // Sparse valid with junk on idle cycles
    for (int i = 0; i < 8; i++) begin
      logic [31:0] v;
      v = 32'h9490_94C4;
      in_valid = 1'b1;
      in_class = v[31-4*i -: 4];
      tick();
      in_valid = 1'b0;
      in_class = 4'd2;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0];
      in_class = 4'd2;
      tick();
    end
    in_valid = 1'b0;
    model(32'h9490_94C4, m_cls, m_votes, m_ill);
    wait_valid(lat);
    chk("sparse_valid", 32'(out_valid), 32'd1);
    chk("sparse_class", 32'(out_class), 32'(m_cls));
    chk("sparse_votes", 32'(out_votes), 32'(m_votes));
    chk("sparse_illegal", 32'(out_illegal), 32'(m_ill));
    tick();
    chk("sparse_consumed", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
